// File: rtl/dmem_access_arbiter_if.sv
// dmem_access_arbiter_if: CPU, debug/DMA and data-memory bus bundle for dmem_access_arbiter
//   slave  : arbiter view (takes requests and memory responses, drives memory port and completions)
//   master : environment view (requesters plus data memory)
interface dmem_access_arbiter_if #(parameter int ADDR_W = 32);
  logic              cpu_req, cpu_we, cpu_unsigned;
  logic [1:0]        cpu_size;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata, cpu_rdata;
  logic              cpu_done, cpu_err, cpu_stall;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata, dbg_rdata;
  logic              dbg_done, dbg_err;
  logic              mem_en, mem_w, mem_ready;
  logic [2:0]        dm_ctrl;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_unsigned, cpu_size, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_err, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done, dbg_err,
    output mem_en, mem_w, dm_ctrl, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
  modport master (
    output cpu_req, cpu_we, cpu_unsigned, cpu_size, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done, dbg_err,
    input  mem_en, mem_w, dm_ctrl, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: shares the data-memory port between the CPU MEM stage and a word-only debug/DMA port
//   clk, rstn : clock, asynchronous active-low reset
//   b         : dmem_access_arbiter_if.slave (cpu_*, dbg_* requesters; mem_*/dm_ctrl memory port)
//   optional  : DMEM_MISALIGN_TRAP_EN completes misaligned requests with an error without issuing them
module dmem_access_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  dmem_access_arbiter_if.slave  b
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q;
  logic              last_dbg_q, gnt_dbg_q, mem_en_q, mem_w_q;
  logic              cpu_done_q, cpu_err_q, dbg_done_q, dbg_err_q;
  logic [2:0]        dm_ctrl_q;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, cpu_rdata_q, dbg_rdata_q;
  logic              req_any, pick_dbg, ld_uns, w_we, w_mis, timeout, fin, fin_dbg, fin_err;
  logic [2:0]        w_ctrl;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata, fin_rdata;
  assign req_any  = b.cpu_req | b.dbg_req;
  // On a tie the port that did not win last time goes first.
  assign pick_dbg = b.dbg_req & (~b.cpu_req | ~last_dbg_q);
  assign ld_uns   = ~b.cpu_we & b.cpu_unsigned;
  assign w_we     = pick_dbg ? b.dbg_we : b.cpu_we;
  assign w_addr   = pick_dbg ? b.dbg_addr : b.cpu_addr;
  assign w_wdata  = pick_dbg ? b.dbg_wdata : b.cpu_wdata;
  assign w_ctrl   = (pick_dbg | b.cpu_size[1]) ? 3'b000 :
                    b.cpu_size[0] ? (ld_uns ? 3'b010 : 3'b001) : (ld_uns ? 3'b100 : 3'b011);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis    = pick_dbg ? |b.dbg_addr[1:0] :
                    b.cpu_size[1] ? |b.cpu_addr[1:0] : (b.cpu_size[0] & b.cpu_addr[0]);
`else
  assign w_mis    = 1'b0;
`endif
  // The counter holds the number of BUSY cycles already spent, so the last allowed cycle is TIMEOUT_CYCLES-1.
  assign timeout   = cnt_q == 8'(TIMEOUT_CYCLES - 1);
  // Completion happens either from BUSY (ready or timeout) or straight from IDLE for a trapped request.
  assign fin       = (state_q == IDLE & req_any & w_mis) | (state_q == BUSY & (b.mem_ready | timeout));
  assign fin_dbg   = (state_q == IDLE) ? pick_dbg : gnt_dbg_q;
  assign fin_rdata = (state_q == BUSY & b.mem_ready & ~mem_w_q) ? b.mem_rdata : '0;
  assign fin_err   = ~(state_q == BUSY & b.mem_ready);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      last_dbg_q  <= 1'b0;
      gnt_dbg_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_w_q     <= 1'b0;
      dm_ctrl_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      cpu_err_q   <= 1'b0;
      dbg_rdata_q <= '0;
      dbg_done_q  <= 1'b0;
      dbg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_any) begin
          gnt_dbg_q <= pick_dbg;
          cnt_q     <= '0;
          if (w_mis) state_q <= DONE;
          else begin
            state_q     <= BUSY;
            mem_en_q    <= 1'b1;
            mem_w_q     <= w_we;
            dm_ctrl_q   <= w_ctrl;
            mem_addr_q  <= w_addr;
            mem_wdata_q <= w_wdata;
          end
        end
        BUSY: if (b.mem_ready | timeout) begin
          state_q  <= DONE;
          mem_en_q <= 1'b0;
          mem_w_q  <= 1'b0;
        end else if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        DONE: begin
          state_q    <= IDLE;
          cpu_done_q <= 1'b0;
          dbg_done_q <= 1'b0;
          last_dbg_q <= gnt_dbg_q;
        end
        default: state_q <= IDLE;
      endcase
      if (fin && fin_dbg) begin
        dbg_done_q  <= 1'b1;
        dbg_rdata_q <= fin_rdata;
        dbg_err_q   <= fin_err;
      end
      if (fin && !fin_dbg) begin
        cpu_done_q  <= 1'b1;
        cpu_rdata_q <= fin_rdata;
        cpu_err_q   <= fin_err;
      end
    end
  end
  assign b.mem_en    = mem_en_q;
  assign b.mem_w     = mem_w_q;
  assign b.dm_ctrl   = dm_ctrl_q;
  assign b.mem_addr  = mem_addr_q;
  assign b.mem_wdata = mem_wdata_q;
  assign b.cpu_rdata = cpu_rdata_q;
  assign b.cpu_done  = cpu_done_q;
  assign b.cpu_err   = cpu_err_q;
  assign b.cpu_stall = b.cpu_req & ~cpu_done_q;
  assign b.dbg_rdata = dbg_rdata_q;
  assign b.dbg_done  = dbg_done_q;
  assign b.dbg_err   = dbg_err_q;
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb_dmem_access_arbiter: directed and randomized check of dmem_access_arbiter against a transaction-level model
module tb_dmem_access_arbiter;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_cpu_rd = '0;
  logic [31:0] m_dbg_rd = '0;
  dmem_access_arbiter_if #(.ADDR_W(32)) bus();
  dmem_access_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rstn(rstn), .b(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset();
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_w", 32'(bus.mem_w), 32'd0);
    chk("rst_dm_ctrl", 32'(bus.dm_ctrl), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_dones", 32'({bus.cpu_done, bus.dbg_done}), 32'd0);
    chk("rst_errs", 32'({bus.cpu_err, bus.dbg_err}), 32'd0);
  endtask
  task automatic do_reset(input bit keep_cpu);
    rstn = 1'b0;
    bus.dbg_req = 1'b0;
    bus.mem_ready = 1'b0;
    if (!keep_cpu) bus.cpu_req = 1'b0;
    #1;
    chk_reset();
    m_cpu_rd = '0;
    m_dbg_rd = '0;
    @(posedge clk);
    #2;
    rstn = 1'b1;
  endtask
  function automatic logic [2:0] exp_ctrl(input bit dbg, input bit we, input logic [1:0] sz, input bit uns);
    if (dbg || sz[1]) return 3'd0;
    if (sz == 2'b01) return (!we && uns) ? 3'd2 : 3'd1;
    return (!we && uns) ? 3'd4 : 3'd3;
  endfunction
  // One access by a single requester; starts in an IDLE cycle, ends in the IDLE cycle after DONE.
  // dly = number of BUSY cycles before mem_ready; negative means the memory never answers.
  task automatic run(input bit dbg, input bit we, input logic [1:0] sz, input bit uns,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd, input int dly);
    logic [2:0] ctrl;
    bit mis, ok_ready, err_e;
    int nb, dc, exp_nb;
    logic [31:0] rd_e;
    ctrl = exp_ctrl(dbg, we, sz, uns);
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = dbg ? (addr[1:0] != 2'b00) : (sz[1] ? (addr[1:0] != 2'b00) : (sz == 2'b01 && addr[0]));
`else
    mis = 1'b0;
`endif
    ok_ready = !mis && dly >= 0 && dly < TO;
    exp_nb = mis ? 0 : (ok_ready ? dly + 1 : TO);
    err_e = !ok_ready;
    rd_e = (ok_ready && !we) ? rd : 32'd0;
    if (dbg) begin
      bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_size = sz; bus.cpu_unsigned = uns;
      bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    bus.mem_rdata = rd;
    bus.mem_ready = 1'b0;
    #1;
    if (!dbg) chk("stall_req", 32'(bus.cpu_stall), 32'd1);
    nb = 0;
    dc = 0;
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_done || bus.dbg_done) dc = c;
      else if (!dbg) chk("stall_wait", 32'(bus.cpu_stall), 32'd1);
      if (bus.mem_en) begin
        nb++;
        chk("mem_addr", bus.mem_addr, addr);
        chk("mem_wdata", bus.mem_wdata, wd);
        chk("mem_w", 32'(bus.mem_w), 32'(we));
        chk("dm_ctrl", 32'(bus.dm_ctrl), 32'(ctrl));
      end
      bus.mem_ready = bus.mem_en && (nb == dly + 1);
    end
    if (dbg) m_dbg_rd = rd_e; else m_cpu_rd = rd_e;
    chk("latency", 32'(dc), 32'(exp_nb + 1));
    chk("busy_cycles", 32'(nb), 32'(exp_nb));
    chk("cpu_done", 32'(bus.cpu_done), 32'(!dbg));
    chk("dbg_done", 32'(bus.dbg_done), 32'(dbg));
    chk("err", 32'(dbg ? bus.dbg_err : bus.cpu_err), 32'(err_e));
    chk("cpu_rdata", bus.cpu_rdata, m_cpu_rd);
    chk("dbg_rdata", bus.dbg_rdata, m_dbg_rd);
    chk("mem_en_idle", 32'(bus.mem_en), 32'd0);
    chk("mem_w_idle", 32'(bus.mem_w), 32'd0);
    if (!dbg) chk("stall_done", 32'(bus.cpu_stall), 32'd0);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("done_pulse", 32'({bus.cpu_done, bus.dbg_done}), 32'd0);
  endtask
  initial begin
    bit r_dbg, r_we, r_uns, last, exp_dbg;
    logic [1:0] r_sz;
    logic [31:0] r_addr, r_wd, r_rd;
    int r_dly, ng;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_size = 0; bus.cpu_unsigned = 0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    do_reset(1'b0);
    run(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run(1'b0, 1'b1, 2'b00, 1'b0, 32'h103, 32'hAB, 32'h11111111, 3);
    run(1'b0, 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 32'h22222222, -1);
    run(1'b0, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h33334444, 0);
    run(1'b0, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h0000F00F, 1);
    run(1'b0, 1'b0, 2'b00, 1'b1, 32'h105, 32'h0, 32'h000000F0, 2);
    run(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, 32'h55555555, 2);
    run(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h0BADF00D, 0);
    run(1'b1, 1'b0, 2'b10, 1'b0, 32'h408, 32'h0, 32'h66666666, -1);
    for (int i = 0; i < 40; i++) begin
      r_dbg = 1'($urandom_range(0, 1));
      r_we = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      r_sz = 2'($urandom_range(0, 3));
      r_addr = $urandom;
      r_wd = $urandom;
      r_rd = $urandom;
      r_dly = int'($urandom_range(0, 5)) - 1;
      if (r_dbg || r_sz[1]) r_addr[1:0] = 2'b00;
      else if (r_sz == 2'b01) r_addr[0] = 1'b0;
      run(r_dbg, r_we, r_sz, r_uns, r_addr, r_wd, r_rd, r_dly);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    do_reset(1'b0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10; bus.cpu_addr = 32'h200;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h300;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    last = 1'b0;
    ng = 0;
    for (int c = 1; c <= 30 && ng < 3; c++) begin
      @(posedge clk);
      #1;
      chk("done_excl", 32'(bus.cpu_done & bus.dbg_done), 32'd0);
      if (bus.mem_en) begin
        exp_dbg = !last;
        last = exp_dbg;
        chk("grant_order", 32'(bus.mem_addr == 32'h300), 32'(exp_dbg));
        chk("grant_cycle", 32'(c), 32'(1 + 3 * ng));
        ng++;
      end
    end
    chk("grants_seen", 32'(ng), 32'd3);
    do_reset(1'b0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_size = 2'b00; bus.cpu_unsigned = 1'b0;
    bus.cpu_addr = 32'h44; bus.cpu_wdata = 32'h5A;
    bus.mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_mem_en", 32'(bus.mem_en), 32'd1);
    chk("pre_rst_mem_w", 32'(bus.mem_w), 32'd1);
    chk("pre_rst_dm_ctrl", 32'(bus.dm_ctrl), 32'd3);
    do_reset(1'b1);
    run(1'b0, 1'b1, 2'b00, 1'b0, 32'h44, 32'h5A, 32'h0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
